mem_bus_arbiter: RTL and testbench

Shares one downstream memory port between three cache-side requesters: ICache refill read (`ird`), DCache refill/uncached read (`drd`) and DCache write-back/uncached write (`dwr`). It sits between the cache interfaces and the bus bridge. It runs one transaction at a time through an address phase, then a data phase, then (for writes) a response phase. Arbitration is fixed-priority (`dwr` > `drd` > `ird`) with an ICache anti-starvation counter.

---
 rtl/mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates three cache-side requesters (ICache read, DCache read, DCache write)
// onto one downstream memory port, one transaction at a time.
module mem_bus_arbiter #(
    parameter int LEN_W        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             ird_req,
    input  logic [31:0]      ird_addr,
    input  logic [LEN_W-1:0] ird_len,
    output logic             ird_gnt,
    output logic             ird_rvalid,
    output logic [31:0]      ird_rdata,
    output logic             ird_rlast,

    input  logic             drd_req,
    input  logic [31:0]      drd_addr,
    input  logic [LEN_W-1:0] drd_len,
    output logic             drd_gnt,
    output logic             drd_rvalid,
    output logic [31:0]      drd_rdata,
    output logic             drd_rlast,

    input  logic             dwr_req,
    input  logic [31:0]      dwr_addr,
    input  logic [LEN_W-1:0] dwr_len,
    output logic             dwr_gnt,
    input  logic             dwr_wvalid,
    input  logic [31:0]      dwr_wdata,
    output logic             dwr_wready,
    output logic             dwr_done,

    output logic             mem_req,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [LEN_W-1:0] mem_len,
    input  logic             mem_ack,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rlast,
    output logic             mem_wvalid,
    output logic [31:0]      mem_wdata,
    output logic             mem_wlast,
    input  logic             mem_wready,
    input  logic             mem_bvalid,

    output logic             busy,
    output logic [2:0]       dbg_state,
    output logic [1:0]       dbg_owner,
    output logic [2:0]       dbg_starve_cnt
);

    // Handshakes: a beat transfers on a cycle where valid and ready are both high;
    // valid never depends on ready, and read beats are forwarded without backpressure.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WRESP = 3'd4
    } state_t;

    localparam logic [1:0] OWN_IRD = 2'd0;
    localparam logic [1:0] OWN_DRD = 2'd1;
    localparam logic [1:0] OWN_DWR = 2'd2;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [2:0]         starve_q, starve_d;

    logic [31:0]        sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               ird_starved;
    logic [2:0]         starve_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IRD;
            beat_q   <= '0;
            len_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        case (owner_q)
            OWN_DWR: begin sel_addr = dwr_addr; sel_len = dwr_len; end
            OWN_DRD: begin sel_addr = drd_addr; sel_len = drd_len; end
            default: begin sel_addr = ird_addr; sel_len = ird_len; end
        endcase
    end

    assign ird_starved = ird_req && ({29'd0, starve_q} >= 32'(STARVE_LIMIT));
    // Saturates so a long run of data-side traffic cannot wrap the counter back to 0.
    assign starve_inc  = (ird_req && (starve_q != 3'd7)) ? starve_q + 3'd1 : starve_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_d     = beat_q;
        len_d      = len_q;
        starve_d   = starve_q;
        ird_gnt    = 1'b0;
        drd_gnt    = 1'b0;
        dwr_gnt    = 1'b0;
        ird_rvalid = 1'b0;
        ird_rdata  = '0;
        ird_rlast  = 1'b0;
        drd_rvalid = 1'b0;
        drd_rdata  = '0;
        drd_rlast  = 1'b0;
        dwr_wready = 1'b0;
        dwr_done   = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_len    = '0;
        mem_wvalid = 1'b0;
        mem_wdata  = '0;
        mem_wlast  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ird_req || drd_req || dwr_req) begin
                    state_d = ADDR;
                    if (ird_starved) begin
                        owner_d  = OWN_IRD;
                        starve_d = '0;
                    end else if (dwr_req) begin
                        owner_d  = OWN_DWR;
                        starve_d = starve_inc;
                    end else if (drd_req) begin
                        owner_d  = OWN_DRD;
                        starve_d = starve_inc;
                    end else begin
                        owner_d  = OWN_IRD;
                        starve_d = '0;
                    end
                end
            end

            ADDR: begin
                mem_req  = 1'b1;
                mem_wr   = (owner_q == OWN_DWR);
                mem_addr = sel_addr;
                mem_len  = sel_len;
                if (mem_ack) begin
                    beat_d = '0;
                    len_d  = sel_len;
                    case (owner_q)
                        OWN_DWR: dwr_gnt = 1'b1;
                        OWN_DRD: drd_gnt = 1'b1;
                        default: ird_gnt = 1'b1;
                    endcase
                    state_d = (owner_q == OWN_DWR) ? WDATA : RDATA;
                end
            end

            RDATA: begin
                if (owner_q == OWN_DRD) begin
                    drd_rvalid = mem_rvalid;
                    drd_rdata  = mem_rdata;
                    drd_rlast  = mem_rlast;
                end else begin
                    ird_rvalid = mem_rvalid;
                    ird_rdata  = mem_rdata;
                    ird_rlast  = mem_rlast;
                end
                if (mem_rvalid && mem_rlast) begin
                    state_d = IDLE;
                end
            end

            WDATA: begin
                mem_wvalid = dwr_wvalid;
                mem_wdata  = dwr_wdata;
                dwr_wready = mem_wready;
                mem_wlast  = (beat_q == len_q);
                if (dwr_wvalid && mem_wready) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == len_q) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                if (mem_bvalid) begin
                    dwr_done = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;
    assign dbg_owner      = owner_q;
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writes, arbitration with starvation
// relief, stray responses, asynchronous reset mid-burst and single-beat bursts.
module tb_mem_bus_arbiter;

    localparam int W = 8;

    logic          clk;
    logic          reset;
    logic          ird_req, drd_req, dwr_req;
    logic [31:0]   ird_addr, drd_addr, dwr_addr;
    logic [W-1:0]  ird_len, drd_len, dwr_len;
    logic          ird_gnt, drd_gnt, dwr_gnt;
    logic          ird_rvalid, drd_rvalid;
    logic [31:0]   ird_rdata, drd_rdata;
    logic          ird_rlast, drd_rlast;
    logic          dwr_wvalid;
    logic [31:0]   dwr_wdata;
    logic          dwr_wready, dwr_done;
    logic          mem_req, mem_wr;
    logic [31:0]   mem_addr;
    logic [W-1:0]  mem_len;
    logic          mem_ack, mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          mem_rlast;
    logic          mem_wvalid;
    logic [31:0]   mem_wdata;
    logic          mem_wlast, mem_wready, mem_bvalid;
    logic          busy;
    logic [2:0]    dbg_state;
    logic [1:0]    dbg_owner;
    logic [2:0]    dbg_starve_cnt;

    logic [2:0]    gnt_v;
    logic [1:0]    rv_v;
    logic [63:0]   all_outs_or;

    int vectors;
    int miscompares;

    mem_bus_arbiter #(.LEN_W(W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ird_req(ird_req), .ird_addr(ird_addr), .ird_len(ird_len), .ird_gnt(ird_gnt),
        .ird_rvalid(ird_rvalid), .ird_rdata(ird_rdata), .ird_rlast(ird_rlast),
        .drd_req(drd_req), .drd_addr(drd_addr), .drd_len(drd_len), .drd_gnt(drd_gnt),
        .drd_rvalid(drd_rvalid), .drd_rdata(drd_rdata), .drd_rlast(drd_rlast),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_len(dwr_len), .dwr_gnt(dwr_gnt),
        .dwr_wvalid(dwr_wvalid), .dwr_wdata(dwr_wdata), .dwr_wready(dwr_wready),
        .dwr_done(dwr_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
        .mem_wlast(mem_wlast), .mem_wready(mem_wready), .mem_bvalid(mem_bvalid),
        .busy(busy), .dbg_state(dbg_state), .dbg_owner(dbg_owner),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    assign gnt_v = {dwr_gnt, drd_gnt, ird_gnt};
    assign rv_v  = {drd_rvalid, ird_rvalid};
    assign all_outs_or = {63'd0, |{ird_gnt, drd_gnt, dwr_gnt, ird_rvalid, drd_rvalid,
                                   ird_rlast, drd_rlast, dwr_wready, dwr_done, mem_req,
                                   mem_wr, mem_wvalid, mem_wlast, busy, ird_rdata,
                                   drd_rdata, mem_addr, mem_len, mem_wdata, dbg_state,
                                   dbg_owner, dbg_starve_cnt}};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [31:0] addr, input logic [W-1:0] len);
        case (who)
            0: begin ird_req = 1'b1; ird_addr = addr; ird_len = len; end
            1: begin drd_req = 1'b1; drd_addr = addr; drd_len = len; end
            default: begin dwr_req = 1'b1; dwr_addr = addr; dwr_len = len; end
        endcase
    endtask

    // Called in the first ADDR cycle of a transaction owned by 'who'
    // (0=ird, 1=drd, 2=dwr); returns in the IDLE cycle that follows it.
    task automatic run_txn(input int who, input logic [31:0] addr, input logic [W-1:0] len,
                           input int ack_wait, input bit toggle);
        int acc;
        int c;
        for (int k = 0; k < ack_wait; k++) begin
            mem_ack = 1'b0;
            #1;
            check("addr_wait", {60'd0, mem_req, gnt_v}, {60'd0, 1'b1, 3'b000});
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check("addr_phase", {22'd0, mem_req, mem_wr, mem_addr, mem_len},
              {22'd0, 1'b1, (who == 2), addr, len});
        check("gnt", {61'd0, gnt_v}, {61'd0, 3'(1 << who)});
        tick();
        mem_ack = 1'b0;
        case (who)
            0: ird_req = 1'b0;
            1: drd_req = 1'b0;
            default: begin dwr_req = 1'b0; dwr_len = ~len; end
        endcase
        if (who != 2) begin
            for (int b = 0; b <= int'(len); b++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = addr + 32'(b * 4);
                mem_rlast  = (b == int'(len));
                #1;
                check("rvalid", {62'd0, rv_v}, (who == 0) ? 64'd1 : 64'd2);
                check("rdata", {32'd0, (who == 0) ? ird_rdata : drd_rdata},
                      {32'd0, addr + 32'(b * 4)});
                check("rlast", {63'd0, (who == 0) ? ird_rlast : drd_rlast},
                      {63'd0, (b == int'(len))});
                tick();
            end
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
        end else begin
            acc = 0;
            c   = 0;
            while (acc <= int'(len)) begin
                mem_wready = toggle ? (c % 2 == 0) : 1'b1;
                dwr_wvalid = 1'b1;
                dwr_wdata  = 32'hD000_0000 + 32'(acc);
                #1;
                check("wbeat", {29'd0, mem_wvalid, mem_wdata, dwr_wready, mem_wlast},
                      {29'd0, 1'b1, 32'hD000_0000 + 32'(acc), mem_wready, (acc == int'(len))});
                if (mem_wready) acc++;
                c++;
                tick();
            end
            dwr_wvalid = 1'b0;
            mem_wready = 1'b0;
            mem_bvalid = 1'b0;
            #1;
            check("wresp_wait", {58'd0, busy, dbg_state, mem_wvalid, dwr_done},
                  {58'd0, 1'b1, 3'd4, 1'b0, 1'b0});
            tick();
            mem_bvalid = 1'b1;
            #1;
            check("done", {63'd0, dwr_done}, 64'd1);
            tick();
            mem_bvalid = 1'b0;
        end
        #1;
        check("end_idle", {60'd0, busy, dbg_state}, 64'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        {ird_req, drd_req, dwr_req} = '0;
        {ird_addr, drd_addr, dwr_addr} = '0;
        {ird_len, drd_len, dwr_len} = '0;
        dwr_wvalid = 1'b0; dwr_wdata = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        mem_wready = 1'b0; mem_bvalid = 1'b0;

        #2 reset = 1'b0;
        #1;
        check("reset_outs", all_outs_or, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // single ICache read, ack in second ADDR cycle
        set_req(0, 32'h1FC0_0000, 8'd3);
        #1;
        check("idle_before", {61'd0, mem_req, busy, ird_gnt}, 64'd0);
        tick();
        check("ird_owner", {59'd0, dbg_state, dbg_owner}, {59'd0, 3'd1, 2'd0});
        run_txn(0, 32'h1FC0_0000, 8'd3, 1, 1'b0);

        // DCache write burst with toggling wready, len changed after grant
        set_req(2, 32'h8000_0040, 8'd3);
        tick();
        run_txn(2, 32'h8000_0040, 8'd3, 0, 1'b1);

        // stray responses while idle
        mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_bvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("stray_fwd", {60'd0, rv_v, dwr_done, mem_req}, 64'd0);
        tick();
        check("stray_state", {60'd0, busy, dbg_state}, 64'd0);
        mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0; mem_rdata = '0;

        // arbitration: all three pending, data-side requests reasserted after each grant
        set_req(0, 32'h0000_1000, 8'd0);
        set_req(1, 32'h0000_2000, 8'd1);
        set_req(2, 32'h0000_3000, 8'd1);
        tick();
        check("arb1", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd2, 3'd1});
        run_txn(2, 32'h0000_3000, 8'd1, 0, 1'b0);
        tick();
        set_req(2, 32'h0000_3100, 8'd0);
        check("arb2", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd1, 3'd2});
        run_txn(1, 32'h0000_2000, 8'd1, 0, 1'b0);
        tick();
        set_req(1, 32'h0000_2100, 8'd0);
        check("arb3", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd2, 3'd3});
        run_txn(2, 32'h0000_3100, 8'd0, 0, 1'b0);
        tick();
        set_req(2, 32'h0000_3200, 8'd0);
        check("arb4", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd1, 3'd4});
        run_txn(1, 32'h0000_2100, 8'd0, 0, 1'b0);
        tick();
        set_req(1, 32'h0000_2200, 8'd0);
        check("arb5_ird", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd0, 3'd0});
        run_txn(0, 32'h0000_1000, 8'd0, 0, 1'b0);
        tick();
        check("arb6", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd2, 3'd0});
        run_txn(2, 32'h0000_3200, 8'd0, 0, 1'b0);
        tick();
        check("arb7", {56'd0, dbg_state, dbg_owner, dbg_starve_cnt}, {56'd0, 3'd1, 2'd1, 3'd0});
        run_txn(1, 32'h0000_2200, 8'd0, 0, 1'b0);

        // asynchronous reset in the middle of an 8-beat DCache read
        set_req(1, 32'h4000_0000, 8'd7);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        drd_req = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h4000_0000 + 32'(b); mem_rlast = 1'b0;
            tick();
        end
        #1;
        check("pre_reset_rvalid", {62'd0, rv_v}, 64'd2);
        reset = 1'b0;
        #1;
        check("async_reset", all_outs_or, 64'd0);
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_idle", {60'd0, busy, dbg_state}, 64'd0);

        // single-beat read and write after reset
        set_req(1, 32'h5000_0000, 8'd0);
        tick();
        run_txn(1, 32'h5000_0000, 8'd0, 0, 1'b0);
        set_req(2, 32'h6000_0000, 8'd0);
        tick();
        run_txn(2, 32'h6000_0000, 8'd0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
